// File: rtl/pico_ctrl.sv
// ============================================================================
//  Module   : pico_ctrl
//  Purpose  : Two-cycle fetch/execute controller for a 4-register pico CPU.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module pico_ctrl #(
    parameter int N   = 8,
    parameter int PCW = 6
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [15:0]    instr,
    input  logic [8:0]     switches,
    input  logic [3:0]     alu_flags,
    output logic [PCW-1:0] pc,
    output logic [2:0]     func,
    output logic [1:0]     a_sel,
    output logic [1:0]     b_sel,
    output logic [N-1:0]   immediate,
    output logic [1:0]     rd_addr,
    output logic [1:0]     rs_addr,
    output logic           reg_we,
    output logic [3:0]     flags_q,
    output logic           halted
);

    localparam logic [2:0] c_RA     = 3'd0;
    localparam logic [2:0] c_RB     = 3'd1;
    localparam logic [2:0] c_RADD   = 3'd2;
    localparam logic [2:0] c_RSUB   = 3'd3;

    localparam logic [1:0] c_REG    = 2'd0;
    localparam logic [1:0] c_SW_7_0 = 2'd1;
    localparam logic [1:0] c_SW_8   = 2'd2;
    localparam logic [1:0] c_IMM    = 2'd3;

    localparam logic [2:0] c_FETCH   = 3'd0;
    localparam logic [2:0] c_EXEC    = 3'd1;
    localparam logic [2:0] c_WAIT_HI = 3'd2;
    localparam logic [2:0] c_WAIT_LO = 3'd3;
    localparam logic [2:0] c_HALT    = 3'd4;

    logic [2:0]     r_state;
    logic [15:0]    r_instr_q;
    logic [3:0]     w_op;
    logic           w_taken;
    logic [PCW-1:0] w_pc_inc;
    logic [PCW-1:0] w_target;
    logic           w_unused;

    // The low switch byte is routed to the ALU outside this block.
    assign w_unused = ^{switches[7:0], c_SW_8};

    assign w_op     = r_instr_q[15:12];
    assign rd_addr  = r_instr_q[11:10];
    assign rs_addr  = r_instr_q[9:8];
    assign w_pc_inc = pc + PCW'(1);
    assign w_target = PCW'(r_instr_q[7:0]);
    assign halted   = (r_state == c_HALT);

    generate
        if (N > 8) begin : g_imm_ext
            assign immediate = {{(N-8){1'b0}}, r_instr_q[7:0]};
        end else begin : g_imm_trunc
            assign immediate = r_instr_q[N-1:0];
        end
    endgenerate

    always_comb begin
        func   = c_RA;
        a_sel  = c_REG;
        b_sel  = c_REG;
        reg_we = 1'b0;
        if (r_state == c_EXEC) begin
            case (w_op)
                4'h1: begin func = c_RADD; reg_we = 1'b1; end
                4'h2: begin func = c_RADD; b_sel = c_IMM; reg_we = 1'b1; end
                4'h3: begin func = c_RSUB; reg_we = 1'b1; end
                4'h4: begin func = c_RSUB; b_sel = c_IMM; reg_we = 1'b1; end
                4'h5: begin func = c_RB;   reg_we = 1'b1; end
                4'h6: begin func = c_RB;   b_sel = c_IMM; reg_we = 1'b1; end
                4'h7: begin a_sel = c_SW_7_0; reg_we = 1'b1; end
                default: ;
            endcase
        end
    end

    // Branch conditions use the flags registered by an earlier instruction.
    always_comb begin
        w_taken = 1'b0;
        case (w_op)
            4'h9: w_taken = flags_q[1];
            4'hA: w_taken = ~flags_q[1];
            4'hB: w_taken = flags_q[2] ^ flags_q[3];
            4'hC: w_taken = 1'b1;
            default: w_taken = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= c_FETCH;
            pc        <= '0;
            r_instr_q <= '0;
            flags_q   <= '0;
        end else begin
            case (r_state)
                c_FETCH: begin
                    r_instr_q <= instr;
                    r_state   <= c_EXEC;
                end
                c_EXEC: begin
                    if (w_op >= 4'h1 && w_op <= 4'h4) begin
                        flags_q <= alu_flags;
                    end
                    case (w_op)
                        4'h8:    r_state <= c_WAIT_HI;
                        4'hF:    r_state <= c_HALT;
                        default: begin
                            pc      <= w_taken ? w_target : w_pc_inc;
                            r_state <= c_FETCH;
                        end
                    endcase
                end
                c_WAIT_HI: begin
                    if (switches[8]) begin
                        r_state <= c_WAIT_LO;
                    end
                end
                c_WAIT_LO: begin
                    if (!switches[8]) begin
                        pc      <= w_pc_inc;
                        r_state <= c_FETCH;
                    end
                end
                c_HALT:  r_state <= c_HALT;
                default: r_state <= c_FETCH;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_pico_ctrl.sv
// ============================================================================
//  Module   : tb_pico_ctrl
//  Purpose  : Scoreboard-driven scenario bench for pico_ctrl.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_pico_ctrl;

    localparam logic [2:0] c_RA   = 3'd0;
    localparam logic [2:0] c_RB   = 3'd1;
    localparam logic [2:0] c_RADD = 3'd2;
    localparam logic [1:0] c_REG  = 2'd0;
    localparam logic [1:0] c_SW   = 2'd1;
    localparam logic [1:0] c_IMM  = 2'd3;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] instr;
    logic [8:0]  switches;
    logic [3:0]  alu_flags;
    logic [5:0]  pc;
    logic [2:0]  func;
    logic [1:0]  a_sel, b_sel, rd_addr, rs_addr;
    logic [7:0]  immediate;
    logic        reg_we;
    logic [3:0]  flags_q;
    logic        halted;

    logic [15:0] rom [64];
    logic [15:0] sb [$];
    logic [15:0] exp_v;
    int          checks = 0;
    int          errors = 0;

    pico_ctrl #(.N(8), .PCW(6)) dut (
        .clk(clk), .reset(reset), .instr(instr), .switches(switches),
        .alu_flags(alu_flags), .pc(pc), .func(func), .a_sel(a_sel),
        .b_sel(b_sel), .immediate(immediate), .rd_addr(rd_addr),
        .rs_addr(rs_addr), .reg_we(reg_we), .flags_q(flags_q), .halted(halted)
    );

    always #5 clk = ~clk;
    assign instr = rom[pc];

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 64; i++) rom[i] = 16'h0000;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        clear_rom();
        switches = '0; alu_flags = 4'hF;
        reset = 1'b1;
        tick(2);
        sb.push_back(16'h0); sb.push_back(16'h0); sb.push_back(16'h0);
        sb.push_back(16'h0); sb.push_back(16'(c_RA));
        exp_v = sb.pop_front(); checks++;
        if (16'(pc) !== exp_v) begin errors++; $display("FAIL reset_pc: got %h expected %h", pc, exp_v); end
        exp_v = sb.pop_front(); checks++;
        if (16'(halted) !== exp_v) begin errors++; $display("FAIL reset_halted: got %h expected %h", halted, exp_v); end
        exp_v = sb.pop_front(); checks++;
        if (16'(reg_we) !== exp_v) begin errors++; $display("FAIL reset_we: got %h expected %h", reg_we, exp_v); end
        exp_v = sb.pop_front(); checks++;
        if (16'(flags_q) !== exp_v) begin errors++; $display("FAIL reset_flags: got %h expected %h", flags_q, exp_v); end
        exp_v = sb.pop_front(); checks++;
        if (16'(func) !== exp_v) begin errors++; $display("FAIL reset_func: got %h expected %h", func, exp_v); end
        reset = 1'b0;
    endtask

    // LDI r1,5 then ADDI r1,0xFB
    task automatic test_ldi_addi();
        clear_rom();
        rom[0] = 16'h6405; rom[1] = 16'h24FB;
        alu_flags = 4'b0011;
        do_reset();
        tick();
        sb.push_back(16'h1); sb.push_back(16'(c_RB)); sb.push_back(16'(c_IMM));
        sb.push_back(16'h05); sb.push_back(16'h1);
        exp_v = sb.pop_front(); checks++;
        if (16'(reg_we) !== exp_v) begin errors++; $display("FAIL ldi_we: got %h expected %h", reg_we, exp_v); end
        exp_v = sb.pop_front(); checks++;
        if (16'(func) !== exp_v) begin errors++; $display("FAIL ldi_func: got %h expected %h", func, exp_v); end
        exp_v = sb.pop_front(); checks++;
        if (16'(b_sel) !== exp_v) begin errors++; $display("FAIL ldi_bsel: got %h expected %h", b_sel, exp_v); end
        exp_v = sb.pop_front(); checks++;
        if (16'(immediate) !== exp_v) begin errors++; $display("FAIL ldi_imm: got %h expected %h", immediate, exp_v); end
        exp_v = sb.pop_front(); checks++;
        if (16'(rd_addr) !== exp_v) begin errors++; $display("FAIL ldi_rd: got %h expected %h", rd_addr, exp_v); end
        tick();
        sb.push_back(16'h0); sb.push_back(16'h0);
        exp_v = sb.pop_front(); checks++;
        if (16'(flags_q) !== exp_v) begin errors++; $display("FAIL ldi_noflags: got %h expected %h", flags_q, exp_v); end
        exp_v = sb.pop_front(); checks++;
        if (16'(reg_we) !== exp_v) begin errors++; $display("FAIL fetch_we: got %h expected %h", reg_we, exp_v); end
        tick();
        sb.push_back(16'(c_RADD)); sb.push_back(16'hFB);
        exp_v = sb.pop_front(); checks++;
        if (16'(func) !== exp_v) begin errors++; $display("FAIL addi_func: got %h expected %h", func, exp_v); end
        exp_v = sb.pop_front(); checks++;
        if (16'(immediate) !== exp_v) begin errors++; $display("FAIL addi_imm: got %h expected %h", immediate, exp_v); end
        tick();
        sb.push_back(16'b0011); sb.push_back(16'h2);
        exp_v = sb.pop_front(); checks++;
        if (16'(flags_q) !== exp_v) begin errors++; $display("FAIL addi_flags: got %h expected %h", flags_q, exp_v); end
        exp_v = sb.pop_front(); checks++;
        if (16'(pc) !== exp_v) begin errors++; $display("FAIL addi_pc: got %h expected %h", pc, exp_v); end
    endtask

    // SUB sets flags, then a conditional branch to 0x20.
    task automatic test_branch(input logic [3:0] bop, input logic [3:0] flg, input logic [5:0] exp_pc);
        clear_rom();
        rom[0] = 16'h3500; rom[1] = {bop, 12'h020};
        alu_flags = flg;
        do_reset();
        tick(2);
        alu_flags = ~flg;
        tick(2);
        sb.push_back(16'(exp_pc)); sb.push_back(16'(flg));
        exp_v = sb.pop_front(); checks++;
        if (16'(pc) !== exp_v) begin errors++; $display("FAIL branch_%h_pc: got %h expected %h", bop, pc, exp_v); end
        exp_v = sb.pop_front(); checks++;
        if (16'(flags_q) !== exp_v) begin errors++; $display("FAIL branch_%h_flags: got %h expected %h", bop, flags_q, exp_v); end
    endtask

    task automatic test_wrap();
        clear_rom();
        rom[0] = 16'hC03F; rom[63] = 16'hC03F;
        do_reset();
        tick(4);
        sb.push_back(16'h3F);
        exp_v = sb.pop_front(); checks++;
        if (16'(pc) !== exp_v) begin errors++; $display("FAIL jmp_self: got %h expected %h", pc, exp_v); end
        rom[63] = 16'h0000;
        do_reset();
        tick(4);
        sb.push_back(16'h0);
        exp_v = sb.pop_front(); checks++;
        if (16'(pc) !== exp_v) begin errors++; $display("FAIL pc_wrap: got %h expected %h", pc, exp_v); end
    endtask

    task automatic test_waitsw();
        clear_rom();
        rom[0] = 16'h8000; rom[1] = 16'h6403;
        switches = '0;
        do_reset();
        tick(2);
        for (int i = 0; i < 10; i++) begin
            sb.push_back(16'h0);
            tick();
            exp_v = sb.pop_front(); checks++;
            if (16'({pc, reg_we}) !== exp_v) begin errors++; $display("FAIL wait_hi_%0d: got pc=%h we=%b expected %h", i, pc, reg_we, exp_v); end
        end
        switches[8] = 1'b1;
        tick(3);
        switches[8] = 1'b0;
        sb.push_back(16'h0);
        exp_v = sb.pop_front(); checks++;
        if (16'({pc, reg_we}) !== exp_v) begin errors++; $display("FAIL wait_lo: got pc=%h we=%b expected %h", pc, reg_we, exp_v); end
        tick();
        sb.push_back(16'h1);
        exp_v = sb.pop_front(); checks++;
        if (16'(pc) !== exp_v) begin errors++; $display("FAIL wait_release_pc: got %h expected %h", pc, exp_v); end
        tick();
        sb.push_back(16'h1);
        exp_v = sb.pop_front(); checks++;
        if (16'(reg_we) !== exp_v) begin errors++; $display("FAIL wait_next_exec: got %h expected %h", reg_we, exp_v); end
    endtask

    task automatic test_halt();
        clear_rom();
        rom[0] = 16'h6007; rom[1] = 16'hF000; rom[2] = 16'h6407;
        do_reset();
        tick(4);
        for (int i = 0; i < 20; i++) begin
            sb.push_back({8'h0, 6'h01, 1'b1, 1'b0});
            tick();
            exp_v = sb.pop_front(); checks++;
            if (16'({8'h0, pc, halted, reg_we}) !== exp_v) begin errors++; $display("FAIL halt_%0d: got pc=%h halted=%b we=%b expected %h", i, pc, halted, reg_we, exp_v); end
        end
        do_reset();
        sb.push_back(16'h0); sb.push_back(16'h0);
        exp_v = sb.pop_front(); checks++;
        if (16'(pc) !== exp_v) begin errors++; $display("FAIL halt_reset_pc: got %h expected %h", pc, exp_v); end
        exp_v = sb.pop_front(); checks++;
        if (16'(halted) !== exp_v) begin errors++; $display("FAIL halt_reset_halted: got %h expected %h", halted, exp_v); end
        tick();
        sb.push_back(16'h1);
        exp_v = sb.pop_front(); checks++;
        if (16'(reg_we) !== exp_v) begin errors++; $display("FAIL halt_reset_fetch: got %h expected %h", reg_we, exp_v); end
    endtask

    // ADD captures flags; D, E and MOV must leave them alone.
    task automatic test_flags_hold();
        clear_rom();
        rom[0] = 16'h1600; rom[1] = 16'hD000; rom[2] = 16'hE000; rom[3] = 16'h5900;
        rom[4] = 16'h7000;
        alu_flags = 4'b1001;
        do_reset();
        tick(2);
        alu_flags = 4'b0110;
        tick(5);
        sb.push_back(16'(c_RB)); sb.push_back(16'h1);
        exp_v = sb.pop_front(); checks++;
        if (16'(func) !== exp_v) begin errors++; $display("FAIL mov_func: got %h expected %h", func, exp_v); end
        exp_v = sb.pop_front(); checks++;
        if (16'(rs_addr) !== exp_v) begin errors++; $display("FAIL mov_rs: got %h expected %h", rs_addr, exp_v); end
        tick();
        sb.push_back(16'b1001); sb.push_back(16'h4);
        exp_v = sb.pop_front(); checks++;
        if (16'(flags_q) !== exp_v) begin errors++; $display("FAIL hold_flags: got %h expected %h", flags_q, exp_v); end
        exp_v = sb.pop_front(); checks++;
        if (16'(pc) !== exp_v) begin errors++; $display("FAIL hold_pc: got %h expected %h", pc, exp_v); end
        tick();
        sb.push_back(16'(c_SW)); sb.push_back(16'h1);
        exp_v = sb.pop_front(); checks++;
        if (16'(a_sel) !== exp_v) begin errors++; $display("FAIL insw_asel: got %h expected %h", a_sel, exp_v); end
        exp_v = sb.pop_front(); checks++;
        if (16'(reg_we) !== exp_v) begin errors++; $display("FAIL insw_we: got %h expected %h", reg_we, exp_v); end
    endtask

    task automatic test_reset_in_exec();
        clear_rom();
        rom[0] = 16'h24FB;
        alu_flags = 4'hF;
        do_reset();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        sb.push_back(16'h0); sb.push_back(16'h0); sb.push_back(16'(c_REG));
        exp_v = sb.pop_front(); checks++;
        if (16'(pc) !== exp_v) begin errors++; $display("FAIL rst_exec_pc: got %h expected %h", pc, exp_v); end
        exp_v = sb.pop_front(); checks++;
        if (16'(flags_q) !== exp_v) begin errors++; $display("FAIL rst_exec_flags: got %h expected %h", flags_q, exp_v); end
        exp_v = sb.pop_front(); checks++;
        if (16'(b_sel) !== exp_v) begin errors++; $display("FAIL rst_exec_bsel: got %h expected %h", b_sel, exp_v); end
    endtask

    initial begin
        reset = 1'b1; switches = '0; alu_flags = '0;
        test_reset();
        test_ldi_addi();
        test_branch(4'h9, 4'b0010, 6'h20);
        test_branch(4'hA, 4'b0010, 6'h02);
        test_branch(4'hB, 4'b0100, 6'h20);
        test_branch(4'hB, 4'b1100, 6'h02);
        test_wrap();
        test_waitsw();
        test_halt();
        test_flags_hold();
        test_reset_in_exec();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
